// File: rtl/array_ops_pkg.sv
// Shared types and constants for the 2D array blocks: the traversal-order
// encoding and the serializer FSM state.
package array_ops_pkg;

    typedef logic [1:0] tile_order_t;

    localparam tile_order_t ORDER_ROW       = 2'd0;
    localparam tile_order_t ORDER_COL       = 2'd1;
    localparam tile_order_t ORDER_SPLIT_COL = 2'd2;
    localparam tile_order_t ORDER_REV_ROW   = 2'd3;

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } ser_state_t;

endpackage

// File: rtl/array_tile_serializer_if.sv
// Tile-in / beat-out bundle of the tile serializer. Both sides are
// valid/ready: a transfer happens on a rising edge where valid & ready are
// both high; valid never waits on ready, and payload is held while stalled.
interface array_tile_serializer_if
    import array_ops_pkg::*;
#(
    parameter int BIT_WIDTH = 4,
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int LANES     = 4
);
    logic [ROWS-1:0][COLS-1:0][BIT_WIDTH-1:0] in;
    tile_order_t                              in_mode;
    logic                                     in_valid;
    logic                                     in_ready;
    logic [LANES*BIT_WIDTH-1:0]               out_data;
    logic                                     out_valid;
    logic                                     out_ready;
    logic                                     out_last;
    logic                                     busy;

    modport master (
        output in, in_mode, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last, busy
    );

    modport slave (
        input  in, in_mode, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last, busy
    );
endinterface

// File: rtl/tile_order_addr_gen.sv
// Combinational traversal-order decoder: maps a linear position to the
// (row, col) of the tile element visited at that position.
module tile_order_addr_gen
    import array_ops_pkg::*;
#(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int SUB_ROWS = 4,
    parameter int PW       = $clog2(ROWS*COLS) + 1
) (
    input  tile_order_t   mode,
    input  logic [PW-1:0] pos,
    output logic [PW-1:0] row,
    output logic [PW-1:0] col
);
    // Divisor for the lower split block; never used when SUB_ROWS == ROWS.
    localparam int R2     = ROWS - SUB_ROWS;
    localparam int R2_DIV = (R2 > 0) ? R2 : 1;

    localparam logic [PW-1:0] ROWS_W     = PW'(ROWS);
    localparam logic [PW-1:0] COLS_W     = PW'(COLS);
    localparam logic [PW-1:0] SUB_W      = PW'(SUB_ROWS);
    localparam logic [PW-1:0] R2_W       = PW'(R2_DIV);
    localparam logic [PW-1:0] SPLIT_W    = PW'(COLS*SUB_ROWS);
    localparam logic [PW-1:0] LAST_POS_W = PW'(ROWS*COLS - 1);

    logic [PW-1:0] q;
    logic [PW-1:0] rp;

    always_comb begin
        row = '0;
        col = '0;
        q   = pos - SPLIT_W;
        rp  = LAST_POS_W - pos;
        case (mode)
            ORDER_ROW: begin
                row = pos / COLS_W;
                col = pos % COLS_W;
            end
            ORDER_COL: begin
                row = pos % ROWS_W;
                col = pos / ROWS_W;
            end
            ORDER_SPLIT_COL: begin
                if (pos < SPLIT_W) begin
                    row = pos % SUB_W;
                    col = pos / SUB_W;
                end else begin
                    row = SUB_W + (q % R2_W);
                    col = q / R2_W;
                end
            end
            default: begin
                row = rp / COLS_W;
                col = rp % COLS_W;
            end
        endcase
    end
endmodule

// File: rtl/array_tile_serializer.sv
// Holds one ROWSxCOLS tile and streams it out as LANES-element beats in the
// selected traversal order; a new tile can be taken on the last beat's edge.
module array_tile_serializer
    import array_ops_pkg::*;
#(
    parameter int BIT_WIDTH = 4,
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int SUB_ROWS  = 4,
    parameter int LANES     = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    array_tile_serializer_if.slave  bus
);
    localparam int N_POS   = ROWS * COLS;
    localparam int N_BEATS = N_POS / LANES;
    localparam int BW      = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam int PW      = $clog2(N_POS) + 1;
    localparam int RIW     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CIW     = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(N_BEATS - 1);

    typedef logic [ROWS-1:0][COLS-1:0][BIT_WIDTH-1:0] tile_t;

    if ((N_POS % LANES) != 0) begin : g_bad_lanes
        $error("ROWS*COLS must be a multiple of LANES");
    end
    if (SUB_ROWS < 1 || SUB_ROWS > ROWS) begin : g_bad_sub_rows
        $error("SUB_ROWS must lie in 1..ROWS");
    end

    ser_state_t  state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    tile_t       tile_q, tile_d;
    tile_order_t mode_q, mode_d;

    logic out_valid_w;
    logic out_last_w;
    logic out_hs;
    logic in_ready_w;
    logic [LANES*BIT_WIDTH-1:0] lane_data;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        tile_d      = tile_q;
        mode_d      = mode_q;
        out_valid_w = (state_q == S_STREAM);
        out_last_w  = out_valid_w && (beat_q == LAST_BEAT);
        out_hs      = out_valid_w && bus.out_ready;
        // Ready on the final handshake so tiles chain without a bubble.
        in_ready_w  = (state_q == S_IDLE) || (out_hs && out_last_w);
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    tile_d  = bus.in;
                    mode_d  = bus.in_mode;
                    beat_d  = '0;
                    state_d = S_STREAM;
                end
            end
            default: begin
                if (out_hs) begin
                    if (!out_last_w) begin
                        beat_d = beat_q + 1'b1;
                    end else if (bus.in_valid) begin
                        tile_d = bus.in;
                        mode_d = bus.in_mode;
                        beat_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            tile_q  <= '0;
            mode_q  <= ORDER_ROW;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            tile_q  <= tile_d;
            mode_q  <= mode_d;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [PW-1:0] pos;
        logic [PW-1:0] row;
        logic [PW-1:0] col;
        logic          lane_unused;

        assign pos = PW'(beat_q) * PW'(LANES) + PW'(l);

        tile_order_addr_gen #(
            .ROWS     (ROWS),
            .COLS     (COLS),
            .SUB_ROWS (SUB_ROWS),
            .PW       (PW)
        ) u_addr (
            .mode (mode_q),
            .pos  (pos),
            .row  (row),
            .col  (col)
        );

        // Indices are always in range, so the upper bits carry no information.
        assign lane_unused = ^{row[PW-1:RIW], col[PW-1:CIW]};
        assign lane_data[l*BIT_WIDTH +: BIT_WIDTH] = tile_q[row[RIW-1:0]][col[CIW-1:0]];
    end

    assign bus.out_data  = out_valid_w ? lane_data : '0;
    assign bus.out_valid = out_valid_w;
    assign bus.out_last  = out_last_w;
    assign bus.in_ready  = in_ready_w;
    assign bus.busy      = (state_q == S_STREAM);
endmodule

// File: tb/tb_array_tile_serializer.sv
// Directed bench for array_tile_serializer: 8x8 tile of 8-bit elements with
// in[r][c] = r*8+c, four lanes, split at row 4.
module tb_array_tile_serializer;
    import array_ops_pkg::*;

    logic clk;
    logic rst_n;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] got[16];
    logic        got_last[16];
    int          col_cycles;
    logic [31:0] exp_q[$];

    array_tile_serializer_if #(
        .BIT_WIDTH (8),
        .ROWS      (8),
        .COLS      (8),
        .LANES     (4)
    ) bus ();

    array_tile_serializer #(
        .BIT_WIDTH (8),
        .ROWS      (8),
        .COLS      (8),
        .SUB_ROWS  (4),
        .LANES     (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver: offer one tile and wait (bounded) until it is taken
    task automatic send_tile(input tile_order_t m);
        int cyc;
        cyc = 0;
        bus.in_mode  = m;
        bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready && cyc < 50) begin
            tick();
            cyc++;
        end
        if (!bus.in_ready) check("send_timeout", 32'(cyc), 32'd0);
        tick();
        bus.in_valid = 1'b0;
    endtask

    // collector: gather 16 beats; with rnd, out_ready toggles and the
    // scoreboard queue supplies each expected beat
    task automatic collect(input bit rnd);
        int   n;
        logic prev_stall;
        logic [31:0] prev_data;
        logic [31:0] exp;
        n = 0;
        col_cycles = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        while (n < 16 && col_cycles < 400) begin
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (rnd && prev_stall) check("stall_hold", bus.out_data, prev_data);
            if (rnd && bus.out_valid && !bus.out_ready) check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            if (bus.out_valid && bus.out_ready) begin
                got[n]      = bus.out_data;
                got_last[n] = bus.out_last;
                if (rnd) begin
                    if (exp_q.size() > 0) begin
                        exp = exp_q.pop_front();
                        check("sb_beat", bus.out_data, exp);
                    end else begin
                        check("sb_extra_beat", 32'(n), 32'd16);
                    end
                end
                n++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            tick();
            col_cycles++;
        end
        if (n < 16) check("collect_timeout", 32'(n), 32'd16);
        bus.out_ready = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_mode   = ORDER_ROW;
        bus.out_ready = 1'b0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                bus.in[r][c] = 8'(r * 8 + c);

        // reset values, and no accept while held in reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        tick();
        check("rst_no_accept", 32'(bus.busy), 32'd0);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // mode 0, full tile at full rate
        bus.out_ready = 1'b1;
        send_tile(ORDER_ROW);
        check("m0_busy", 32'(bus.busy), 32'd1);
        collect(1'b0);
        check("m0_cycles", 32'(col_cycles), 32'd16);
        for (int b = 0; b < 16; b++) begin
            check($sformatf("m0_beat%0d", b), got[b], pk(4*b, 4*b+1, 4*b+2, 4*b+3));
            check($sformatf("m0_last%0d", b), 32'(got_last[b]), 32'(b == 15));
        end
        check("m0_idle_busy", 32'(bus.busy), 32'd0);
        check("m0_idle_valid", 32'(bus.out_valid), 32'd0);
        check("m0_idle_in_ready", 32'(bus.in_ready), 32'd1);

        // mode 1
        send_tile(ORDER_COL);
        collect(1'b0);
        check("m1_beat0", got[0], pk(0, 8, 16, 24));
        check("m1_beat2", got[2], pk(1, 9, 17, 25));
        check("m1_beat15", got[15], pk(39, 47, 55, 63));

        // mode 3
        send_tile(ORDER_REV_ROW);
        collect(1'b0);
        check("m3_beat0", got[0], pk(63, 62, 61, 60));
        check("m3_beat15", got[15], pk(3, 2, 1, 0));

        // mode 2; in_mode changes after accept and must be ignored
        send_tile(ORDER_SPLIT_COL);
        bus.in_mode = ORDER_ROW;
        collect(1'b0);
        check("m2_beat0", got[0], pk(0, 8, 16, 24));
        check("m2_beat4", got[4], pk(4, 12, 20, 28));
        check("m2_beat8", got[8], pk(32, 40, 48, 56));
        check("m2_beat15", got[15], pk(39, 47, 55, 63));
        check("m2_last15", 32'(got_last[15]), 32'd1);

        // back-to-back: second tile taken on the last beat's edge
        send_tile(ORDER_ROW);
        for (int b = 0; b < 15; b++) begin
            if (b == 14) check("b2b_in_ready_beat14", 32'(bus.in_ready), 32'd0);
            tick();
        end
        check("b2b_last_a", 32'(bus.out_last), 32'd1);
        check("b2b_beat15_a", bus.out_data, pk(60, 61, 62, 63));
        bus.in_mode  = ORDER_COL;
        bus.in_valid = 1'b1;
        #1;
        check("b2b_in_ready_last", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("b2b_valid_next", 32'(bus.out_valid), 32'd1);
        check("b2b_beat0_b", bus.out_data, pk(0, 8, 16, 24));
        check("b2b_in_ready_after", 32'(bus.in_ready), 32'd0);
        check("b2b_last_b0", 32'(bus.out_last), 32'd0);
        repeat (15) tick();
        check("b2b_beat15_b", bus.out_data, pk(39, 47, 55, 63));
        check("b2b_last_b", 32'(bus.out_last), 32'd1);
        tick();
        check("b2b_idle", 32'(bus.busy), 32'd0);

        // random backpressure, mode 0 with scoreboard
        for (int b = 0; b < 16; b++) exp_q.push_back(pk(4*b, 4*b+1, 4*b+2, 4*b+3));
        send_tile(ORDER_ROW);
        collect(1'b1);
        check("rnd_sb_empty", 32'(exp_q.size()), 32'd0);
        check("rnd_last15", 32'(got_last[15]), 32'd1);
        check("rnd_last14", 32'(got_last[14]), 32'd0);
        check("rnd_idle", 32'(bus.busy), 32'd0);

        // asynchronous reset while beat 7 is showing
        bus.out_ready = 1'b1;
        send_tile(ORDER_ROW);
        repeat (7) tick();
        check("mid_beat7", bus.out_data, pk(28, 29, 30, 31));
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_data", bus.out_data, 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_last", 32'(bus.out_last), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_valid", 32'(bus.out_valid), 32'd0);
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        send_tile(ORDER_REV_ROW);
        check("post_rst_beat0", bus.out_data, pk(63, 62, 61, 60));
        check("post_rst_last0", 32'(bus.out_last), 32'd0);
        collect(1'b0);
        check("post_rst_cycles", 32'(col_cycles), 32'd16);
        check("post_rst_beat15", got[15], pk(3, 2, 1, 0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
